dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set depth to 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, legal range 0..15, SHALL set the extra cycles inserted before each access.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1 bit: request present.
REQ-006 Port req_ready, output, 1 bit: block can accept a request this cycle.
REQ-007 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_addr, input, 32 bits: byte address.
REQ-009 Port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port req_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-011 Port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 Port rsp_valid, output, 1 bit: response present, exactly one cycle.
REQ-013 Port rsp_rdata, output, 32 bits: extended load data; 0 for stores and faults.
REQ-014 Port rsp_fault, output, 1 bit: access rejected.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; all req_* fields SHALL be captured at that edge and later input changes SHALL be ignored.
REQ-017 On acceptance, the FSM SHALL go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, else directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at counter 0, the next edge SHALL go to RESP.
REQ-019 The memory access (store commit or load sample) SHALL occur on the edge entering RESP.
REQ-020 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; the response is not back-pressured.
REQ-021 rsp_valid SHALL rise WAIT_STATES+1 cycles after the accept edge; the next request can be accepted no earlier than the cycle after RESP.
REQ-022 Word index SHALL be req_addr[ADDR_WIDTH+1:2] and byte lane SHALL be req_addr[1:0].
REQ-023 The block SHALL fault if size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or any req_addr bit above ADDR_WIDTH+1 is set.
REQ-024 A faulting access SHALL not modify memory and SHALL respond with rsp_fault=1 and rsp_rdata=0 at normal latency.
REQ-025 A byte store SHALL write only lane addr[1:0] with wdata[7:0].
REQ-026 A half store SHALL write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
REQ-027 A word store SHALL write all four lanes; lanes not written SHALL keep their contents.
REQ-028 A byte or half load SHALL shift the selected lanes to bit 0 and extend to 32 bits per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-029 A load following a store to the same word SHALL return the stored data.
REQ-030 Memory SHALL initialise to all zeros at time 0.

Reset
REQ-031 While rst is high: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0.
REQ-032 Memory contents SHALL be unaffected by rst.
REQ-033 rst asserted mid-operation SHALL drop the pending request with no response; a store not yet committed SHALL never commit.
REQ-034 The first accept after rst deasserts SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-035 Word store 0xDEADBEEF to 0x10, then signed word load from 0x10 with WAIT_STATES=1 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept, fault=0.
REQ-036 After REQ-035, byte store 0x55 to 0x11, then signed byte load at 0x13 and unsigned half load at 0x10 -> 0xFFFFFFDE and 0x000055EF; word load at 0x10 -> 0xDEAD55EF.
REQ-037 Half load at 0x03, word store at 0x12, and size=11 at 0x00 -> each gives rsp_fault=1, rsp_rdata=0, and memory is unchanged on read-back.
REQ-038 Load at address 1<<(ADDR_WIDTH+2) -> fault; word load at the last word (4*2^ADDR_WIDTH-4) -> no fault.
REQ-039 Accept word store 0x12345678 to 0x20 with WAIT_STATES=3, pulse rst during WAIT -> no rsp_valid; read-back of 0x20 returns its prior value.
REQ-040 With WAIT_STATES=0 and req_valid held high, ten back-to-back loads -> each rsp_valid pulse lasts one cycle, one accept every 2 cycles, and req_ready=0 during RESP.

Source files
------------

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: one outstanding access at a time, a fixed number of
// wait states before each access, byte/half/word loads and stores, and faults
// for misaligned, illegal-size or out-of-range requests.
module dmem_bytelane #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [1:0]              lane_q, lane_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    fault_q, fault_d;

  logic                    accept;
  logic                    enter_resp;
  logic                    misalign;
  logic                    out_of_range;
  logic                    req_fault;
  logic                    acc_we;
  logic                    acc_fault;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [1:0]              acc_lane;
  logic [1:0]              acc_size;
  logic [31:0]             acc_wdata;
  logic [3:0]              lane_we;
  logic [31:0]             rd_word;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  // The access edge is the one entering RESP: end of the wait count, or the
  // accept edge itself when there are no wait states.
  assign enter_resp = ((state_q == WAIT) && (cnt_q == 4'd0)) ||
                      (accept && (WAIT_STATES == 0));

  // Classify the incoming request as misaligned, illegal-size or out of range.
  always_comb begin
    out_of_range = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
    req_fault = misalign || out_of_range;
  end

  // Access fields: live request on a zero-wait accept edge, captured copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_fault = req_fault;
      acc_idx   = req_addr[ADDR_WIDTH+1:2];
      acc_lane  = req_addr[1:0];
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_fault = fault_q;
      acc_idx   = idx_q;
      acc_lane  = lane_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
  end

  // Lane write enables; faulting stores never touch memory.
  always_comb begin
    lane_we = 4'b0000;
    if (enter_resp && acc_we && !acc_fault) begin
      case (acc_size)
        2'b00:   lane_we[acc_lane] = 1'b1;
        2'b01:   lane_we = acc_lane[1] ? 4'b1100 : 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH] = '{default: 8'h00};
    logic [7:0] wbyte;
    logic [7:0] rd_byte_q;

    // Route the right-aligned store data onto this lane.
    always_comb begin
      case (acc_size)
        2'b00:   wbyte = acc_wdata[7:0];
        2'b01:   wbyte = acc_wdata[8*(gi%2) +: 8];
        default: wbyte = acc_wdata[8*gi +: 8];
      endcase
    end

    // Lane storage with registered read; contents are untouched by reset.
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem[acc_idx] <= wbyte;
      end
      if (enter_resp) begin
        rd_byte_q <= mem[acc_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_q;
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_WIDTH+1:2];
          lane_d  = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          fault_d = req_fault;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset drops any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
    end
  end

  assign load_byte = rd_word[{lane_q, 3'b000} +: 8];
  assign load_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

  // Align and extend load data; stores and faults return zero.
  always_comb begin
    rsp_rdata = 32'd0;
    if ((state_q == RESP) && !we_q && !fault_q) begin
      case (size_q)
        2'b00:   rsp_rdata = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
        2'b01:   rsp_rdata = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
        default: rsp_rdata = rd_word;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_fault = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: three instances (1, 3 and 0 wait states) share the
// request bus; a byte-addressed memory model predicts every response and the
// ready/valid pattern each cycle, and directed transactions pin literal values.
module tb_dmem_bytelane;
  localparam int AW = 10;
  localparam int NB = 4 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  int          sel = 0;

  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        rf  [3];
  logic        vin0, vin1, vin2;

  assign vin0 = req_valid && (sel == 0);
  assign vin1 = req_valid && (sel == 1);
  assign vin2 = req_valid && (sel == 2);

  always #5 clk = ~clk;

  dmem_bytelane #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .req_valid(vin0), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_fault(rf[0]));
  dmem_bytelane #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req_valid(vin1), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_fault(rf[1]));
  dmem_bytelane #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req_valid(vin2), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_fault(rf[2]));

  // Model state: byte-addressed memory per instance and one pending access each.
  logic [7:0]  mm [3][NB];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        pend [3];
  int          due [3];
  logic        p_we [3];
  logic        p_fault [3];
  logic [31:0] p_addr [3];
  logic [31:0] p_wdata [3];
  logic [1:0]  p_size [3];
  logic [31:0] e_rdata [3];
  logic        cmp_ev;

  function automatic int ws(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic mfault(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (a >= 32'(NB));
  endfunction

  function automatic logic [31:0] mload(input int k, input logic [31:0] a,
                                        input logic [1:0] sz, input logic u);
    int i;
    logic [15:0] h;
    i = int'(a[11:0]);
    case (sz)
      2'd0:    return u ? {24'd0, mm[k][i]} : {{24{mm[k][i][7]}}, mm[k][i]};
      2'd1: begin
        h = {mm[k][i+1], mm[k][i]};
        return u ? {16'd0, h} : {{16{h[15]}}, h};
      end
      default: return {mm[k][i+3], mm[k][i+2], mm[k][i+1], mm[k][i]};
    endcase
  endfunction

  function automatic void mstore(input int k, input logic [31:0] a,
                                 input logic [1:0] sz, input logic [31:0] wd);
    int i;
    i = int'(a[11:0]);
    mm[k][i] = wd[7:0];
    if (sz != 2'd0) mm[k][i+1] = wd[15:8];
    if (sz == 2'd2) begin
      mm[k][i+2] = wd[23:16];
      mm[k][i+3] = wd[31:24];
    end
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d got=%08h want=%08h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: on each edge accept, commit stores at the access edge, retire after RESP.
  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      due[k]  = 0;
      for (int i = 0; i < NB; i++) mm[k][i] = 8'h00;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 3; k++) pend[k] = 1'b0;
      end else begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
          if (!pend[k] && req_valid && sel == k) begin
            pend[k]    = 1'b1;
            due[k]     = cyc + ws(k);
            p_we[k]    = req_we;
            p_addr[k]  = req_addr;
            p_size[k]  = req_size;
            p_wdata[k] = req_wdata;
            p_fault[k] = mfault(req_addr, req_size);
            e_rdata[k] = (req_we || p_fault[k]) ? 32'd0 :
                         mload(k, req_addr, req_size, req_unsigned);
          end else if (pend[k] && cyc == due[k] + 1) begin
            pend[k] = 1'b0;
          end
          if (pend[k] && cyc == due[k] && p_we[k] && !p_fault[k])
            mstore(k, p_addr[k], p_size[k], p_wdata[k]);
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp_ev = !rst && pend[k] && (cyc == due[k]);
      chk("req_ready", k, 32'(rdy[k]), 32'(!rst && !pend[k]));
      chk("rsp_valid", k, 32'(rv[k]), 32'(cmp_ev));
      if (cmp_ev) begin
        chk("rsp_rdata", k, rd[k], e_rdata[k]);
        chk("rsp_fault", k, 32'(rf[k]), 32'(p_fault[k]));
      end
      if (rst) begin
        chk("rst_rdata", k, rd[k], 32'd0);
        chk("rst_fault", k, 32'(rf[k]), 32'd0);
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [31:0] addr,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    int t;
    t = 0;
    req_valid = 1'b0;
    sel = k;
    @(negedge clk);
    while (!rdy[k] && t < 32) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", k, 32'(rdy[k]), 32'd1);
    req_we = we;
    req_addr = addr;
    req_size = sz;
    req_unsigned = u;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the bus so late changes would show up if not captured.
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = $urandom;
    req_size = 2'($urandom_range(0, 3));
    req_unsigned = ~u;
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp(input int k, output logic [31:0] rdata, output logic flt, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv[k] && lat < 32);
    chk("rsp_seen", k, 32'(rv[k]), 32'd1);
    rdata = rd[k];
    flt = rf[k];
  endtask

  task automatic xact(input int k, input logic we, input logic [31:0] addr, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic flt, output int lat);
    issue(k, we, addr, sz, u, wd);
    wait_rsp(k, rdata, flt, lat);
    $display("xact inst=%0d we=%0d addr=%08h size=%0d uns=%0d wdata=%08h -> rdata=%08h fault=%0d lat=%0d",
             k, we, addr, sz, u, wd, rdata, flt, lat);
  endtask

  logic [31:0] r;
  logic        f;
  int          l;
  int          pulses;
  int          consec;
  logic        prev;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // One wait state: store/load round trips, lane merging, faults, range edges.
    xact(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, r, f, l);
    chk("st_w_fault", 0, 32'(f), 32'd0);
    chk("st_w_rdata", 0, r, 32'd0);
    xact(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("ld_w", 0, r, 32'hDEADBEEF);
    chk("ld_w_lat", 0, l, 32'd2);
    chk("ld_w_fault", 0, 32'(f), 32'd0);
    xact(0, 1'b1, 32'h11, 2'd0, 1'b0, 32'hAAAA_AA55, r, f, l);
    xact(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, r, f, l);
    chk("ld_b_s", 0, r, 32'hFFFFFFDE);
    xact(0, 1'b0, 32'h10, 2'd1, 1'b1, 32'h0, r, f, l);
    chk("ld_h_u", 0, r, 32'h000055EF);
    xact(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("ld_w_merged", 0, r, 32'hDEAD55EF);
    xact(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, r, f, l);
    chk("ld_h_s_hi", 0, r, 32'hFFFFDEAD);
    xact(0, 1'b0, 32'h03, 2'd1, 1'b0, 32'h0, r, f, l);
    chk("misal_h_fault", 0, 32'(f), 32'd1);
    chk("misal_h_rdata", 0, r, 32'd0);
    xact(0, 1'b1, 32'h12, 2'd2, 1'b0, 32'hFFFFFFFF, r, f, l);
    chk("misal_w_st_fault", 0, 32'(f), 32'd1);
    xact(0, 1'b0, 32'h00, 2'd3, 1'b0, 32'h0, r, f, l);
    chk("size3_fault", 0, 32'(f), 32'd1);
    chk("size3_rdata", 0, r, 32'd0);
    xact(0, 1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'hFFFFFFFF, r, f, l);
    chk("hi_st_fault", 0, 32'(f), 32'd1);
    xact(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("readback_10", 0, r, 32'hDEAD55EF);
    xact(0, 1'b0, 32'h00, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("readback_00", 0, r, 32'd0);
    xact(0, 1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("range_fault", 0, 32'(f), 32'd1);
    xact(0, 1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("last_word_fault", 0, 32'(f), 32'd0);
    chk("last_word_rdata", 0, r, 32'd0);
    xact(0, 1'b1, 32'hFFF, 2'd0, 1'b0, 32'h1234_5680, r, f, l);
    xact(0, 1'b0, 32'hFFE, 2'd1, 1'b0, 32'h0, r, f, l);
    chk("ld_h_s_top", 0, r, 32'hFFFF8000);
    xact(0, 1'b0, 32'hFFF, 2'd0, 1'b1, 32'h0, r, f, l);
    chk("ld_b_u_top", 0, r, 32'h00000080);
    xact(0, 1'b0, 32'hFFC, 2'd2, 1'b1, 32'h0, r, f, l);
    chk("ld_w_uns_ignored", 0, r, 32'h80000000);

    // Three wait states: reset during WAIT drops the store and its response.
    xact(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, r, f, l);
    chk("ws3_lat", 1, l, 32'd4);
    issue(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    chk("rst_no_rsp", 1, pulses, 32'd0);
    xact(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("rst_no_commit", 1, r, 32'hCAFEF00D);

    // Zero wait states: single latency, then back-to-back loads with valid held.
    xact(2, 1'b0, 32'h00, 2'd2, 1'b0, 32'h0, r, f, l);
    chk("ws0_lat", 2, l, 32'd1);
    xact(2, 1'b1, 32'h04, 2'd2, 1'b0, 32'h11223344, r, f, l);
    sel = 2;
    req_we = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    @(negedge clk);
    chk("b2b_start_ready", 2, 32'(rdy[2]), 32'd1);
    req_valid = 1'b1;
    pulses = 0;
    consec = 0;
    prev = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1 req_addr = 32'(((j + 1) % 4) * 4);
      @(negedge clk);
      if (rv[2]) begin
        pulses++;
        if (prev) consec++;
      end
      prev = rv[2];
    end
    req_valid = 1'b0;
    chk("b2b_pulses", 2, pulses, 32'd10);
    chk("b2b_one_cycle", 2, consec, 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
